regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Next-generation multi-port register file for the MIPS datapath. NW write
//  ports and NR read ports, register 0 hardwired to zero, same-cycle
//  write-to-read bypass, async reset of all contents. Per-register pending
//  scoreboard lets issue logic stall on operands whose producer has not written back.
// PARAMETERS
//  DATA_SIZE   32  register width in bits
//  SELEC_SIZE  5   register address width
//  ADDRESSES   32  number of registers (<= 2**SELEC_SIZE)
//  NR          2   number of read ports
//  NW          2   number of write ports; higher index has priority
// PORTS
//  clk       in   1               rising-edge clock
//  rst       in   1               reset, asynchronous, active-high
//  rs        in   NR*SELEC_SIZE   read addresses; port r = rs[r*SELEC_SIZE +: SELEC_SIZE]
//  Q         out  NR*DATA_SIZE    read data; port r = Q[r*DATA_SIZE +: DATA_SIZE]
//  Qv        out  NR              read data valid (operand not pending), per read port
//  we        in   NW              write enable per write port
//  rd        in   NW*SELEC_SIZE   write addresses, packed as rs
//  D         in   NW*DATA_SIZE    write data, packed as Q
//  pend_set  in   1               mark register pend_addr as awaiting a write
//  pend_addr in   SELEC_SIZE      register to mark pending
//  pend_cnt  out  $clog2(ADDRESSES+1)  number of registers currently pending
// BEHAVIOUR
//  - Reset: rst=1 immediately clears all mem entries and pending bits; pend_cnt=0;
//    all Q=0 and all Qv=1 while rst is high (outputs are combinational from state).
//  - Write (posedge clk): for each w with we[w]=1 and rd[w]!=0, mem[rd[w]]<=D[w].
//    Writes to address 0 ignored. Multiple ports on the same address: highest w wins.
//  - Addresses >= ADDRESSES: writes ignored, reads return 0 with Qv=1.
//  - Read (combinational, 0-cycle latency): rs[r]==0 -> Q=0. Else if any w has
//    we[w]=1 and rd[w]==rs[r], Q = D of highest such w (bypass); else Q=mem[rs[r]].
//  - Scoreboard (posedge clk): pending[a] set when pend_set=1 and pend_addr==a!=0;
//    cleared when any enabled write port targets a. Same-cycle set and write to
//    the same a: set wins (new producer issued), pending[a]=1 next cycle.
//    pend_set to an already-pending register: stays 1, no count change.
//  - Qv[r] = 1 if rs[r]==0, or pending[rs[r]]==0, or a same-cycle enabled write
//    targets rs[r] (bypass satisfies operand); else 0.
//  - pend_cnt: registered, always equals popcount(pending); updated each edge by
//    +1 for a new set, -1 per distinct cleared register, net in one cycle.
//  - No other state; no read-side hazards; reset mid-cycle aborts any write.
// TESTING
//  1. Reset then read all 32 regs on both ports -> Q=0, Qv=1, pend_cnt=0.
//  2. we=2'b11, rd0=rd1=5, D0=0xAAAA, D1=0x5555; next read rs0=5 -> 0x5555;
//     same cycle rs1=5 -> bypass 0x5555 before edge.
//  3. we[0]=1, rd0=0, D0=0xFFFF_FFFF -> read rs0=0 returns 0, pend_cnt unchanged.
//  4. pend_set, pend_addr=8 -> next cycle rs0=8 gives Qv=0, pend_cnt=1; then write
//     reg 8 D=0x1234 -> Qv=1 and Q=0x1234 that cycle, pend_cnt=0 after edge.
//  5. pend_set addr 9 with same-cycle write to 9 -> pending[9]=1, pend_cnt=1.
//  6. Set pending on regs 3,4, write 0x77 to reg 3, assert rst mid-cycle ->
//     Q(3)=0, Qv all 1, pend_cnt=0 without waiting for clk.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write ports and pending-scoreboard controls.
// The issue/writeback side uses master; the register file uses slave.
interface regfile_mp_if #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned SELEC_SIZE = 5,
    parameter int unsigned ADDRESSES  = 32,
    parameter int unsigned NR         = 2,
    parameter int unsigned NW         = 2
);
    localparam int unsigned CntW = $clog2(ADDRESSES + 1);

    logic [NR*SELEC_SIZE-1:0] rs;
    logic [NR*DATA_SIZE-1:0]  Q;
    logic [NR-1:0]            Qv;
    logic [NW-1:0]            we;
    logic [NW*SELEC_SIZE-1:0] rd;
    logic [NW*DATA_SIZE-1:0]  D;
    logic                     pend_set;
    logic [SELEC_SIZE-1:0]    pend_addr;
    logic [CntW-1:0]          pend_cnt;

    modport master (
        output rs, we, rd, D, pend_set, pend_addr,
        input  Q, Qv, pend_cnt
    );

    modport slave (
        input  rs, we, rd, D, pend_set, pend_addr,
        output Q, Qv, pend_cnt
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with r0 hardwired to zero, same-cycle write bypass
// and a per-register pending scoreboard for operand readiness.
module regfile_mp #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned SELEC_SIZE = 5,
    parameter int unsigned ADDRESSES  = 32,
    parameter int unsigned NR         = 2,
    parameter int unsigned NW         = 2
) (
    input logic          clk,
    input logic          rst,
    regfile_mp_if.slave  bus_io
);
    localparam int unsigned CntW = $clog2(ADDRESSES + 1);

    logic [DATA_SIZE-1:0]  mem_q [ADDRESSES];
    logic [DATA_SIZE-1:0]  mem_d [ADDRESSES];
    logic [ADDRESSES-1:0]  pend_q, pend_d;
    logic [CntW-1:0]       pend_cnt_q, pend_cnt_d;

    logic [SELEC_SIZE-1:0] wa;
    logic [SELEC_SIZE-1:0] ra;
    logic [DATA_SIZE-1:0]  rdata;
    logic                  rvalid;

    function automatic logic in_range(input logic [SELEC_SIZE-1:0] a);
        return (32'(a) < ADDRESSES);
    endfunction

    // Ascending port order makes the highest-index port win on collisions.
    always_comb begin
        mem_d = mem_q;
        pend_d = pend_q;
        wa = '0;
        for (int w = 0; w < NW; w++) begin
            wa = bus_io.rd[w*SELEC_SIZE +: SELEC_SIZE];
            if (bus_io.we[w] && wa != '0 && in_range(wa)) begin
                mem_d[wa] = bus_io.D[w*DATA_SIZE +: DATA_SIZE];
                pend_d[wa] = 1'b0;
            end
        end
        // A new producer issued in the same cycle outranks the retiring write.
        if (bus_io.pend_set && bus_io.pend_addr != '0 && in_range(bus_io.pend_addr)) begin
            pend_d[bus_io.pend_addr] = 1'b1;
        end
        pend_cnt_d = '0;
        for (int a = 0; a < ADDRESSES; a++) begin
            pend_cnt_d = pend_cnt_d + CntW'(pend_d[a]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < ADDRESSES; a++) begin
                mem_q[a] <= '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    always_comb begin
        bus_io.Q  = '0;
        bus_io.Qv = '1;
        ra = '0;
        rdata = '0;
        rvalid = 1'b1;
        for (int r = 0; r < NR; r++) begin
            ra = bus_io.rs[r*SELEC_SIZE +: SELEC_SIZE];
            rdata = '0;
            rvalid = 1'b1;
            if (!rst && ra != '0 && in_range(ra)) begin
                rdata = mem_q[ra];
                rvalid = !pend_q[ra];
                for (int w = 0; w < NW; w++) begin
                    if (bus_io.we[w] && bus_io.rd[w*SELEC_SIZE +: SELEC_SIZE] == ra) begin
                        rdata = bus_io.D[w*DATA_SIZE +: DATA_SIZE];
                        rvalid = 1'b1;
                    end
                end
            end
            bus_io.Q[r*DATA_SIZE +: DATA_SIZE] = rdata;
            bus_io.Qv[r] = rvalid;
        end
    end

    assign bus_io.pend_cnt = pend_cnt_q;
endmodule
